ctrl_seq_p: RTL and testbench
=============================

CTRL_SEQ_P -- requirements
Module: ctrl_seq_p

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: 1 enables the mem_ready wait-state handshake; 0 ignores mem_ready.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum consecutive stall cycles before a timeout; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.

Ports, one per line: name, direction, width, meaning.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_  in  1  asynchronous, active-low reset.
REQ-006 opcode  in  3  current instruction opcode (opcode_t).
REQ-007 zero  in  1  accumulator-zero flag.
REQ-008 mem_ready  in  1  memory read data valid.
REQ-009 resume  in  1  single-cycle pulse that releases a HLT-induced halt.
REQ-010 mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  out  1 each  datapath controls.
REQ-011 phase  out  4  current state (state_t).
REQ-012 stalled  out  1  high while a wait state is being inserted.
REQ-013 timeout_err  out  1  sticky memory-timeout flag.
REQ-014 instr_cnt  out  CNT_W  count of retired instructions.

Function
REQ-015 Phase register SHALL follow INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR, advancing one state per clk, except as stated in REQ-020..REQ-025.
REQ-016 Outputs SHALL be combinational decode of the registered phase and the current opcode. ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-017 Decode per state:
- INST_ADDR: all outputs 0.
- INST_FETCH: mem_rd=1.
- INST_LOAD and IDLE: mem_rd=1, load_ir=1.
- OP_ADDR: inc_pc=1, halt=(opcode==HLT).
REQ-018 Decode per state (continued):
- OP_FETCH: mem_rd=ALUOP.
- ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
- STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
- Any output not listed for a state is 0.
REQ-019 HALTED state: halt=1, all other outputs 0.
REQ-020 In OP_ADDR with opcode==HLT, the next state SHALL be HALTED instead of OP_FETCH.
REQ-021 HALTED SHALL exit to INST_ADDR on the first cycle resume=1, unless timeout_err=1. resume in any other state SHALL be ignored.
REQ-022 When MEM_WAIT_EN=1, the phase SHALL hold while mem_ready=0 in these cases:
- in INST_FETCH;
- in OP_FETCH with ALUOP=1.
While holding, stalled=1 and the state's outputs are held.
REQ-023 Stall counter: incremented each stalled cycle, cleared on any phase advance.
REQ-024 Timeout: when the stall counter reaches TIMEOUT with mem_ready still 0, the next state SHALL be HALTED and timeout_err SHALL be set to 1. timeout_err stays set until reset.
REQ-025 If mem_ready=1 in the same cycle the stall counter reaches TIMEOUT, the phase SHALL advance normally and no timeout SHALL occur.
REQ-026 instr_cnt SHALL increment on each STORE -> INST_ADDR transition and wrap from 2^CNT_W-1 to 0. The HLT instruction SHALL NOT be counted.
REQ-027 The default branch of the phase decode SHALL force the phase to INST_ADDR, so the state machine is never left in an illegal state.

Reset
REQ-028 rst_=0 SHALL, asynchronously and mid-operation included, set phase=INST_ADDR, stall counter=0, instr_cnt=0, timeout_err=0. All outputs then decode to 0.
REQ-029 Reset SHALL override resume, mem_ready and any pending timeout. The first transition after reset is INST_ADDR -> INST_FETCH on the first rising edge with rst_=1.

Structure
REQ-030 opcode_t (3-bit: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) and state_t (4-bit: the nine states above, HALTED=8) SHALL reside in the shared package cpu_pkg.
REQ-031 The wait/timeout logic SHALL be one sub-module, ctrl_wait_timer: inputs are the stall request, mem_ready and clear; outputs are stalled and a timeout pulse.

Verification
REQ-032 Reset, then opcode=ADD, mem_ready=1: phase cycles 0..7 in 8 clocks; load_ac=1 only in ALU_OP and STORE; instr_cnt=1 after STORE.
REQ-033 opcode=SKZ, zero=1: inc_pc=1 in OP_ADDR and ALU_OP. With zero=0: inc_pc=1 in OP_ADDR only.
REQ-034 opcode=HLT: halt=1 in OP_ADDR, then HALTED for 5 cycles; resume pulse -> INST_ADDR next cycle; instr_cnt unchanged.
REQ-035 opcode=LDA, mem_ready held 0 for 3 cycles in OP_FETCH: stalled=1 for 3 cycles, then ALU_OP. TIMEOUT=4 with mem_ready held 0: HALTED with timeout_err=1; a later resume is ignored.
REQ-036 rst_ asserted in ALU_OP with instr_cnt=5: phase=INST_ADDR and instr_cnt=0 immediately, without waiting for a clock edge.
REQ-037 With CNT_W=2, run 4 instructions: instr_cnt goes 1, 2, 3, 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU control sequencer: opcodes, phase
// encoding and the ALU-class opcode decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Width of the wait-state counter; large enough for any legal TIMEOUT.
  localparam int STALL_CNT_W = 8;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Wait-state timer: counts consecutive cycles spent waiting on memory and
// flags a timeout once TIMEOUT wait cycles have already been inserted.
module ctrl_wait_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_,
  input  logic stall_req,
  input  logic mem_ready,
  input  logic clear,
  output logic stalled,
  output logic timeout
);

  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(TIMEOUT);

  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;
  logic                   waiting;
  logic                   at_limit;

  // Waiting on memory: either insert another wait state or, once the limit
  // of inserted wait states is used up, give up with a timeout pulse.
  always_comb begin
    waiting  = stall_req && !mem_ready;
    at_limit = (cnt_q == LIMIT);
    stalled  = waiting && !at_limit;
    timeout  = waiting && at_limit;
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stalled) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  // Wait-state counter register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_seq_p.sv
// Control sequencer for a simple accumulator CPU. An eight-phase instruction
// cycle with a HALTED state, optional memory wait states with a timeout, and
// a retired-instruction counter. Outputs decode the registered phase and the
// live opcode.
module ctrl_seq_p
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic [3:0]       phase,
  output logic             stalled,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic             timeout_err_q;
  logic             timeout_err_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] instr_cnt_d;

  opcode_t op;
  logic    aluop;
  logic    stall_req;
  logic    tmo;
  logic    advance;

  assign op    = opcode_t'(opcode);
  assign aluop = is_aluop(op);

  // Memory-read phases that may need to wait for mem_ready.
  always_comb begin
    stall_req = 1'b0;
    if (MEM_WAIT_EN != 0) begin
      stall_req = (state_q == INST_FETCH) || ((state_q == OP_FETCH) && aluop);
    end
  end

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk       (clk),
    .rst_      (rst_),
    .stall_req (stall_req),
    .mem_ready (mem_ready),
    .clear     (advance),
    .stalled   (stalled),
    .timeout   (tmo)
  );

  // Next-phase selection and datapath control decode.
  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      INST_ADDR: begin
        state_d = INST_FETCH;
      end
      INST_FETCH: begin
        mem_rd  = 1'b1;
        state_d = INST_LOAD;
      end
      INST_LOAD: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
        state_d = OP_ADDR;
      end
      OP_ADDR: begin
        inc_pc  = 1'b1;
        halt    = (op == HLT);
        state_d = (op == HLT) ? HALTED : OP_FETCH;
      end
      OP_FETCH: begin
        mem_rd  = aluop;
        state_d = ALU_OP;
      end
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == SKZ) && zero;
        load_pc = (op == JMP);
        state_d = STORE;
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == JMP);
        load_pc = (op == JMP);
        mem_wr  = (op == STO);
        state_d = INST_ADDR;
      end
      HALTED: begin
        halt = 1'b1;
        // A memory timeout is fatal: only reset leaves HALTED after one.
        if (resume && !timeout_err_q) begin
          state_d = INST_ADDR;
        end
      end
      default: begin
        state_d = INST_ADDR;
      end
    endcase
    // Wait states hold the phase (and so its decoded outputs); an exhausted
    // wait budget abandons the access and halts.
    if (tmo) begin
      state_d = HALTED;
    end else if (stalled) begin
      state_d = state_q;
    end
  end

  // Sticky timeout flag and retired-instruction counter updates.
  always_comb begin
    advance       = (state_d != state_q);
    timeout_err_d = timeout_err_q || tmo;
    instr_cnt_d   = instr_cnt_q;
    // STORE always returns to INST_ADDR; HLT never reaches STORE so it is not counted.
    if (state_q == STORE) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  // Phase, timeout flag and counter registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= INST_ADDR;
      timeout_err_q <= 1'b0;
      instr_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      timeout_err_q <= timeout_err_d;
      instr_cnt_q   <= instr_cnt_d;
    end
  end

  assign phase       = state_q;
  assign timeout_err = timeout_err_q;
  assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_ctrl_seq_p.sv
// Scoreboard bench for ctrl_seq_p: the stimulus pushes hand-computed expected
// responses; a monitor pops and compares them against the DUT outputs.
module tb_ctrl_seq_p;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Control vectors ordered {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}.
  localparam logic [6:0] Z    = 7'b0000000;
  localparam logic [6:0] RD   = 7'b1000000;
  localparam logic [6:0] RDIR = 7'b1100000;
  localparam logic [6:0] PC   = 7'b0001000;
  localparam logic [6:0] RDAC = 7'b1000100;
  localparam logic [6:0] HL   = 7'b0010000;
  localparam logic [6:0] HLPC = 7'b0011000;

  // Per-phase expected controls (phase 0 in the top 7 bits).
  localparam logic [55:0] ADD_O  = {Z, RD, RDIR, RDIR, PC, RD, RDAC, RDAC};
  localparam logic [55:0] SKZ1_O = {Z, RD, RDIR, RDIR, PC, Z, PC, Z};
  localparam logic [55:0] SKZ0_O = {Z, RD, RDIR, RDIR, PC, Z, Z, Z};
  localparam logic [55:0] JMP_O  = {Z, RD, RDIR, RDIR, PC, Z, 7'b0000010, 7'b0001010};
  localparam logic [55:0] STO_O  = {Z, RD, RDIR, RDIR, PC, Z, Z, 7'b0000001};

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        rst_b = 1'b1;
  logic [2:0]  opcode = OP_ADD;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        resume = 1'b0;

  logic        mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [3:0]  phase;
  logic        stalled, timeout_err;
  logic [15:0] instr_cnt;

  logic        b_mem_rd, b_load_ir, b_halt, b_inc_pc, b_load_ac, b_load_pc, b_mem_wr;
  logic [3:0]  b_phase;
  logic        b_stalled, b_timeout_err;
  logic [1:0]  b_instr_cnt;

  always #5 clk = ~clk;

  ctrl_seq_p #(.MEM_WAIT_EN(1), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .phase(phase),
    .stalled(stalled), .timeout_err(timeout_err), .instr_cnt(instr_cnt)
  );

  ctrl_seq_p #(.MEM_WAIT_EN(1), .TIMEOUT(15), .CNT_W(2)) dut_b (
    .clk(clk), .rst_(rst_b), .opcode(OP_ADD), .zero(1'b0), .mem_ready(1'b1),
    .resume(1'b0), .mem_rd(b_mem_rd), .load_ir(b_load_ir), .halt(b_halt),
    .inc_pc(b_inc_pc), .load_ac(b_load_ac), .load_pc(b_load_pc), .mem_wr(b_mem_wr),
    .phase(b_phase), .stalled(b_stalled), .timeout_err(b_timeout_err),
    .instr_cnt(b_instr_cnt)
  );

  typedef struct {
    bit          which;
    logic [3:0]  ph;
    logic [6:0]  ctl;
    logic        st;
    logic        terr;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  event sample_now;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input bit which, input logic [3:0] ph, input logic [6:0] ctl,
                      input logic st, input logic terr, input logic [15:0] cnt,
                      input string nm);
    exp_t e;
    e.which = which; e.ph = ph; e.ctl = ctl; e.st = st; e.terr = terr; e.cnt = cnt;
    e.name = nm;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs, expect the response for the current phase.
  task automatic vec(input logic [2:0] op, input logic z, input logic mr, input logic rs,
                     input logic [3:0] ph, input logic [6:0] ctl, input logic st,
                     input logic terr, input logic [15:0] cnt, input string nm);
    opcode = op; zero = z; mem_ready = mr; resume = rs;
    push(1'b0, ph, ctl, st, terr, cnt, nm);
    @(posedge clk); #1;
  endtask

  // A full instruction, with optional wait states in INST_FETCH / OP_FETCH.
  task automatic instr(input logic [2:0] op, input logic z, input logic [55:0] rows,
                       input logic [15:0] cnt, input int st1, input int st5, input string nm);
    logic [6:0] o;
    for (int p = 0; p < 8; p++) begin
      o = rows[55-7*p -: 7];
      if (p == 1) for (int k = 0; k < st1; k++) vec(op, z, 1'b0, 1'b0, 4'd1, o, 1'b1, 1'b0, cnt, {nm, "_ifwait"});
      if (p == 5) for (int k = 0; k < st5; k++) vec(op, z, 1'b0, 1'b0, 4'd5, o, 1'b1, 1'b0, cnt, {nm, "_opwait"});
      vec(op, z, 1'b1, 1'b0, 4'(p), o, 1'b0, 1'b0, cnt, nm);
    end
  endtask

  // Phases INST_ADDR..IDLE, common to every opcode.
  task automatic prefix(input logic [2:0] op, input logic [15:0] cnt, input string nm);
    vec(op, 1'b0, 1'b1, 1'b0, 4'd0, Z, 1'b0, 1'b0, cnt, nm);
    vec(op, 1'b0, 1'b1, 1'b0, 4'd1, RD, 1'b0, 1'b0, cnt, nm);
    vec(op, 1'b0, 1'b1, 1'b0, 4'd2, RDIR, 1'b0, 1'b0, cnt, nm);
    vec(op, 1'b0, 1'b1, 1'b0, 4'd3, RDIR, 1'b0, 1'b0, cnt, nm);
  endtask

  // Monitor: compare whenever an expectation is due.
  initial begin
    exp_t        e;
    logic [3:0]  a_ph;
    logic [6:0]  a_ctl;
    logic        a_st, a_terr;
    logic [15:0] a_cnt;
    forever begin
      @(negedge clk or sample_now);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.which) begin
          a_ph = phase; a_ctl = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
          a_st = stalled; a_terr = timeout_err; a_cnt = instr_cnt;
        end else begin
          a_ph = b_phase;
          a_ctl = {b_mem_rd, b_load_ir, b_halt, b_inc_pc, b_load_ac, b_load_pc, b_mem_wr};
          a_st = b_stalled; a_terr = b_timeout_err; a_cnt = {14'd0, b_instr_cnt};
        end
        n_checks++;
        if (a_ph !== e.ph || a_ctl !== e.ctl || a_st !== e.st || a_terr !== e.terr || a_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s @%0t: got phase=%0d ctl=%b stalled=%b terr=%b cnt=%0d, want phase=%0d ctl=%b stalled=%b terr=%b cnt=%0d",
                   e.name, $time, a_ph, a_ctl, a_st, a_terr, a_cnt, e.ph, e.ctl, e.st, e.terr, e.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    #2 rst_ = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    vec(OP_ADD, 1'b0, 1'b1, 1'b0, 4'd0, Z, 1'b0, 1'b0, 16'd0, "reset");
    rst_ = 1'b1;

    instr(OP_ADD, 1'b0, ADD_O, 16'd0, 0, 0, "add");
    instr(OP_SKZ, 1'b1, SKZ1_O, 16'd1, 0, 0, "skz_z1");
    instr(OP_SKZ, 1'b0, SKZ0_O, 16'd2, 0, 0, "skz_z0");
    instr(OP_JMP, 1'b0, JMP_O, 16'd3, 2, 0, "jmp");
    instr(OP_STO, 1'b0, STO_O, 16'd4, 0, 0, "sto");

    // HLT: halt in OP_ADDR, stay HALTED until resume, not counted.
    prefix(OP_HLT, 16'd5, "hlt");
    vec(OP_HLT, 1'b0, 1'b1, 1'b0, 4'd4, HLPC, 1'b0, 1'b0, 16'd5, "hlt_opaddr");
    for (int k = 0; k < 5; k++) vec(OP_HLT, 1'b0, 1'b1, 1'b0, 4'd8, HL, 1'b0, 1'b0, 16'd5, "hlt_halted");
    vec(OP_HLT, 1'b0, 1'b1, 1'b1, 4'd8, HL, 1'b0, 1'b0, 16'd5, "hlt_resume");

    // LDA with three operand wait states, then async reset in ALU_OP.
    prefix(OP_LDA, 16'd5, "lda");
    vec(OP_LDA, 1'b0, 1'b1, 1'b0, 4'd4, PC, 1'b0, 1'b0, 16'd5, "lda");
    for (int k = 0; k < 3; k++) vec(OP_LDA, 1'b0, 1'b0, 1'b0, 4'd5, RD, 1'b1, 1'b0, 16'd5, "lda_wait");
    vec(OP_LDA, 1'b0, 1'b1, 1'b0, 4'd5, RD, 1'b0, 1'b0, 16'd5, "lda_ready");
    push(1'b0, 4'd6, RDAC, 1'b0, 1'b0, 16'd5, "lda_aluop");
    @(negedge clk); #2;
    rst_ = 1'b0;
    #1;
    push(1'b0, 4'd0, Z, 1'b0, 1'b0, 16'd0, "async_reset");
    -> sample_now;
    @(posedge clk); #1;
    vec(OP_ADD, 1'b0, 1'b1, 1'b0, 4'd0, Z, 1'b0, 1'b0, 16'd0, "reset_held");
    rst_ = 1'b1;

    // mem_ready arrives exactly when the wait budget is used up: no timeout.
    instr(OP_ADD, 1'b0, ADD_O, 16'd0, 0, 4, "to_boundary");

    // Wait budget exhausted: HALTED, sticky error, resume ignored.
    prefix(OP_LDA, 16'd1, "lda_to");
    vec(OP_LDA, 1'b0, 1'b1, 1'b0, 4'd4, PC, 1'b0, 1'b0, 16'd1, "lda_to");
    for (int k = 0; k < 4; k++) vec(OP_LDA, 1'b0, 1'b0, 1'b0, 4'd5, RD, 1'b1, 1'b0, 16'd1, "lda_to_wait");
    vec(OP_LDA, 1'b0, 1'b0, 1'b0, 4'd5, RD, 1'b0, 1'b0, 16'd1, "lda_to_expire");
    vec(OP_LDA, 1'b0, 1'b0, 1'b0, 4'd8, HL, 1'b0, 1'b1, 16'd1, "timeout_halt");
    vec(OP_LDA, 1'b0, 1'b1, 1'b1, 4'd8, HL, 1'b0, 1'b1, 16'd1, "timeout_resume");
    vec(OP_LDA, 1'b0, 1'b1, 1'b0, 4'd8, HL, 1'b0, 1'b1, 16'd1, "timeout_stuck");
    rst_ = 1'b0;
    vec(OP_ADD, 1'b0, 1'b1, 1'b0, 4'd0, Z, 1'b0, 1'b0, 16'd0, "timeout_reset");
    rst_ = 1'b1;

    // Two-bit counter wraps after four instructions.
    rst_b = 1'b1;
    push(1'b1, 4'd0, Z, 1'b0, 1'b0, 16'd0, "wrap_start");
    for (int k = 1; k <= 4; k++) begin
      repeat (8) @(posedge clk);
      #1;
      push(1'b1, 4'd0, Z, 1'b0, 1'b0, 16'(k % 4), "wrap_cnt");
    end

    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
